ram_controller_ex_lfsr_gen: RTL and testbench

Parametrised test-pattern generator and checker for the RAM controller example driver. It replaces the single 8-bit LFSR with a WIDTH-bit generator built from independent per-byte-lane LFSRs. It adds three deterministic pattern modes and an optional compare/error-count stage. One instance drives write data; a second instance, stepped in lockstep, checks read-back data.

---
 rtl/ram_controller_ex_lfsr_gen.sv | 143 ++++++++++++++
 tb/tb_ram_controller_ex_lfsr_gen.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_controller_ex_lfsr_gen.sv
// Test-pattern generator (per-byte-lane LFSR, counter, walking-one, checkerboard)
// with an optional read-back checker compiled in by RAM_CONTROLLER_EX_LFSR_CHECK_EN.
module ram_controller_ex_lfsr_gen #(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned SEED        = 32,
    parameter int unsigned LANE_STRIDE = 1
) (
    input  logic                   i_clk,
    input  logic                   i_reset_n,
    input  logic                   i_enable,
    input  logic                   i_pause,
    input  logic                   i_load,
    input  logic [1:0]             i_mode,
    input  logic [WIDTH-1:0]       i_ldata,
    output logic [WIDTH-1:0]       o_data,
    input  logic                   i_chk_valid,
    input  logic [WIDTH-1:0]       i_chk_data,
    input  logic                   i_chk_clear,
    output logic                   o_chk_fail,
    output logic [15:0]            o_err_count,
    output logic [(WIDTH/8)-1:0]   o_err_lane_mask
);

    localparam int unsigned LANES = WIDTH / 8;

    localparam logic [1:0] MODE_LFSR  = 2'b00;
    localparam logic [1:0] MODE_COUNT = 2'b01;
    localparam logic [1:0] MODE_WALK  = 2'b10;
    localparam logic [1:0] MODE_CHECK = 2'b11;

    // Lane seeds never come out zero, so an LFSR lane cannot lock up.
    function automatic logic [WIDTH-1:0] f_seed_word();
        logic [WIDTH-1:0] w;
        logic [7:0]       s;
        w = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            s = 8'((SEED + i * LANE_STRIDE) % 256);
            if (s == 8'h00) s = 8'h01;
            w[i*8 +: 8] = s;
        end
        return w;
    endfunction

    localparam logic [WIDTH-1:0] SEED_WORD = f_seed_word();

    logic [WIDTH-1:0] r_data;
    logic [WIDTH-1:0] w_init;
    logic [WIDTH-1:0] w_step;
    logic [WIDTH-1:0] w_next;

    // Init word and one-step update for the selected mode.
    always_comb begin
        w_init = '0;
        w_step = r_data;
        case (i_mode)
            MODE_LFSR: begin
                w_init = SEED_WORD;
                for (int unsigned i = 0; i < LANES; i++) begin
                    w_step[i*8 + 0] = r_data[i*8 + 7];
                    w_step[i*8 + 1] = r_data[i*8 + 0];
                    w_step[i*8 + 2] = r_data[i*8 + 1] ^ r_data[i*8 + 7];
                    w_step[i*8 + 3] = r_data[i*8 + 2] ^ r_data[i*8 + 7];
                    w_step[i*8 + 4] = r_data[i*8 + 3] ^ r_data[i*8 + 7];
                    w_step[i*8 + 5] = r_data[i*8 + 4];
                    w_step[i*8 + 6] = r_data[i*8 + 5];
                    w_step[i*8 + 7] = r_data[i*8 + 6];
                end
            end
            MODE_COUNT: begin
                w_init = '0;
                w_step = r_data + WIDTH'(1);
            end
            MODE_WALK: begin
                w_init = WIDTH'(1);
                w_step = {r_data[WIDTH-2:0], r_data[WIDTH-1]};
            end
            MODE_CHECK: begin
                w_init = {LANES{8'h55}};
                w_step = ~r_data;
            end
            default: begin
                w_init = '0;
                w_step = r_data;
            end
        endcase
    end

    always_comb begin
        w_next = w_step;
        if (!i_enable)    w_next = w_init;
        else if (i_load)  w_next = i_ldata;
        else if (i_pause) w_next = r_data;
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) r_data <= SEED_WORD;
        else            r_data <= w_next;
    end

    assign o_data = r_data;

`ifdef RAM_CONTROLLER_EX_LFSR_CHECK_EN
    logic [LANES-1:0] w_lane_mis;
    logic             r_chk_fail;
    logic [15:0]      r_err_count;
    logic [LANES-1:0] r_err_lane_mask;

    always_comb begin
        w_lane_mis = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            w_lane_mis[i] = (i_chk_data[i*8 +: 8] != r_data[i*8 +: 8]);
        end
    end

    // Clear beats a same-cycle mismatch; the counter saturates but flags keep updating.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_chk_fail      <= 1'b0;
            r_err_count     <= 16'h0000;
            r_err_lane_mask <= '0;
        end else if (i_chk_clear) begin
            r_chk_fail      <= 1'b0;
            r_err_count     <= 16'h0000;
            r_err_lane_mask <= '0;
        end else if (i_chk_valid && i_enable && (w_lane_mis != '0)) begin
            r_chk_fail      <= 1'b1;
            r_err_lane_mask <= r_err_lane_mask | w_lane_mis;
            if (r_err_count != 16'hFFFF) r_err_count <= r_err_count + 16'd1;
        end
    end

    assign o_chk_fail      = r_chk_fail;
    assign o_err_count     = r_err_count;
    assign o_err_lane_mask = r_err_lane_mask;
`else
    logic w_unused_chk;
    assign w_unused_chk    = ^{i_chk_valid, i_chk_data, i_chk_clear};
    assign o_chk_fail      = 1'b0;
    assign o_err_count     = 16'h0000;
    assign o_err_lane_mask = '0;
`endif

endmodule

// File: tb/tb_ram_controller_ex_lfsr_gen.sv
// Directed bench for ram_controller_ex_lfsr_gen (WIDTH=16, SEED=32, LANE_STRIDE=1)
// with a cycle-level reference model and per-cycle compare.
module tb_ram_controller_ex_lfsr_gen;

    localparam int unsigned W  = 16;
    localparam int unsigned NL = W / 8;
`ifdef RAM_CONTROLLER_EX_LFSR_CHECK_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          enable, pause, load;
    logic [1:0]    mode;
    logic [W-1:0]  ldata;
    logic [W-1:0]  data;
    logic          chk_valid, chk_clear;
    logic [W-1:0]  chk_data;
    logic          chk_fail;
    logic [15:0]   err_count;
    logic [NL-1:0] err_lane_mask;

    int n_tests = 0;
    int n_fail  = 0;
    bit cmp_on  = 1'b0;

    always #5 clk = ~clk;

    ram_controller_ex_lfsr_gen #(.WIDTH(W), .SEED(32), .LANE_STRIDE(1)) dut (
        .i_clk(clk), .i_reset_n(rst_n), .i_enable(enable), .i_pause(pause),
        .i_load(load), .i_mode(mode), .i_ldata(ldata), .o_data(data),
        .i_chk_valid(chk_valid), .i_chk_data(chk_data), .i_chk_clear(chk_clear),
        .o_chk_fail(chk_fail), .o_err_count(err_count), .o_err_lane_mask(err_lane_mask)
    );

    // Reference model: byte lanes as GF(2^8) multiply-by-x with reduction 0x1D.
    logic [W-1:0]  m_data;
    logic          m_fail;
    logic [15:0]   m_cnt;
    logic [NL-1:0] m_mask;
    logic [W-1:0]  m_nd;
    logic [NL-1:0] m_mis;
    logic [7:0]    m_b;

    function automatic logic [W-1:0] seed_word();
        logic [W-1:0] w;
        int s;
        w = '0;
        for (int i = 0; i < int'(NL); i++) begin
            s = (32 + i) % 256;
            if (s == 0) s = 1;
            w[i*8 +: 8] = 8'(s);
        end
        return w;
    endfunction

    function automatic logic [W-1:0] model_step(input logic [1:0] md, input logic [W-1:0] d);
        logic [W-1:0] r;
        logic [7:0]   b;
        r = d;
        case (md)
            2'b00: for (int i = 0; i < int'(NL); i++) begin
                       b = d[i*8 +: 8];
                       r[i*8 +: 8] = {b[6:0], 1'b0} ^ (b[7] ? 8'h1D : 8'h00);
                   end
            2'b01: r = d + 16'd1;
            2'b10: r = (d << 1) | (d >> (W - 1));
            default: r = d ^ 16'hFFFF;
        endcase
        return r;
    endfunction

    function automatic logic [W-1:0] model_init(input logic [1:0] md);
        case (md)
            2'b00:   return seed_word();
            2'b01:   return 16'h0000;
            2'b10:   return 16'h0001;
            default: return 16'h5555;
        endcase
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_data = seed_word();
            m_fail = 1'b0;
            m_cnt  = 16'h0000;
            m_mask = '0;
        end else begin
            for (int i = 0; i < int'(NL); i++) begin
                m_b = m_data[i*8 +: 8];
                m_mis[i] = (chk_data[i*8 +: 8] != m_b);
            end
            if (!enable)    m_nd = model_init(mode);
            else if (load)  m_nd = ldata;
            else if (pause) m_nd = m_data;
            else            m_nd = model_step(mode, m_data);
            if (CHK_EN) begin
                if (chk_clear) begin
                    m_fail = 1'b0;
                    m_cnt  = 16'h0000;
                    m_mask = '0;
                end else if (chk_valid && enable && m_mis != '0) begin
                    m_fail = 1'b1;
                    m_mask = m_mask | m_mis;
                    if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
                end
            end
            m_data = m_nd;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_on) begin
            check("cyc_data", 32'(data), 32'(m_data));
            check("cyc_chk_fail", 32'(chk_fail), 32'(m_fail));
            check("cyc_err_count", 32'(err_count), 32'(m_cnt));
            check("cyc_lane_mask", 32'(err_lane_mask), 32'(m_mask));
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst_n = 1'b0; enable = 1'b1; pause = 1'b1; load = 1'b0; mode = 2'b00;
        ldata = '0; chk_valid = 1'b0; chk_data = '0; chk_clear = 1'b0;
        #2;
        cmp_on = 1'b1;
        tick(2);
        check("reset_data", 32'(data), 32'h2120);
        check("reset_chk", 32'({chk_fail, err_count, err_lane_mask}), 32'h0);
        rst_n = 1'b1;
        tick();
        check("lfsr_release", 32'(data), 32'h2120);
        pause = 1'b0;
        tick();
        check("lfsr_step1", 32'(data), 32'h4240);
        load = 1'b1; ldata = 16'h8080;
        tick();
        load = 1'b0;
        tick();
        check("lfsr_load_step", 32'(data), 32'h1D1D);

        mode = 2'b01; enable = 1'b0;
        tick();
        check("cnt_init", 32'(data), 32'h0000);
        enable = 1'b1;
        tick(3);
        check("cnt_3steps", 32'(data), 32'h0003);
        load = 1'b1; ldata = 16'hFFFF;
        tick();
        load = 1'b0;
        tick();
        check("cnt_wrap", 32'(data), 32'h0000);

        mode = 2'b10; enable = 1'b0;
        tick();
        check("walk_init", 32'(data), 32'h0001);
        enable = 1'b1;
        tick(16);
        check("walk_16", 32'(data), 32'h0001);
        load = 1'b1; ldata = 16'h8000;
        tick();
        load = 1'b0;
        tick();
        check("walk_wrap", 32'(data), 32'h0001);
        pause = 1'b1; load = 1'b1; ldata = 16'h00F0;
        tick();
        check("load_over_pause", 32'(data), 32'h00F0);
        load = 1'b0; pause = 1'b0;

        mode = 2'b11; enable = 1'b0; load = 1'b1; ldata = 16'h1234;
        tick();
        check("chk_init_over_load", 32'(data), 32'h5555);
        enable = 1'b1; load = 1'b0;
        tick();
        check("chkb_step", 32'(data), 32'hAAAA);
        pause = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("chkb_pause", 32'(data), 32'hAAAA);
        end
        pause = 1'b0; mode = 2'b00;
        tick();
        check("mode_change_no_reinit", 32'(data), 32'h4949);

        // Checker scenarios start from a fresh SEED_WORD held by pause.
        rst_n = 1'b0; pause = 1'b1;
        tick();
        rst_n = 1'b1;
        tick();
        chk_valid = 1'b1; chk_data = 16'h2220;
        tick();
        check("chk_fail", 32'(chk_fail), CHK_EN ? 32'h1 : 32'h0);
        check("chk_count", 32'(err_count), CHK_EN ? 32'h1 : 32'h0);
        check("chk_mask", 32'(err_lane_mask), CHK_EN ? 32'h2 : 32'h0);
        chk_clear = 1'b1; chk_data = 16'h0000;
        tick();
        check("chk_clear_wins", 32'({chk_fail, err_count, err_lane_mask}), 32'h0);
        chk_clear = 1'b0; enable = 1'b0;
        tick();
        check("chk_ignored_disabled", 32'(err_count), 32'h0);
        enable = 1'b1;
        tick();
        enable = 1'b1; chk_data = 16'h0000;
        if (CHK_EN) tick(65540);
        else        tick(20);
        check("sat_count", 32'(err_count), CHK_EN ? 32'hFFFF : 32'h0);
        check("sat_mask", 32'(err_lane_mask), CHK_EN ? 32'h3 : 32'h0);
        rst_n = 1'b0;
        #1;
        check("midrun_rst_data", 32'(data), 32'h2120);
        check("midrun_rst_chk", 32'({chk_fail, err_count, err_lane_mask}), 32'h0);
        tick();
        check("rst_held_data", 32'(data), 32'h2120);
        chk_valid = 1'b0; pause = 1'b0; mode = 2'b01;
        rst_n = 1'b1;
        tick();
        check("post_rst_first_step", 32'(data), 32'h2121);
        tick(2);
        cmp_on = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
